io_input_conditioner: RTL
=========================

// Module: io_input_conditioner
// PURPOSE
//  N-channel debouncer/event latch for discrete IO inputs (limit switches, beam breaks).
//  Replaces the fixed 10-tap shift debounce with a per-channel synchroniser, stability counter and edge detector.
//  Adds per-channel polarity, sticky rise/fall flags and a 32-bit status word for the CPU IO read register.
//  Sticky flags are cleared through a CPU write command from the IO write register.
// PARAMETERS
//  N_CH            4    number of input channels, 1..10 (3*N_CH must be <= 32)
//  DEBOUNCE_CYCLES 1000 consecutive stable samples needed to accept a new level, >= 1
//  CNT_W           16   stability counter width; 2**CNT_W must be > DEBOUNCE_CYCLES
//  INVERT_MASK     0    bit i = 1 inverts raw_in[i] before synchronising (active-low sensors)
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      asynchronous active-low reset
//  raw_in      in   N_CH   asynchronous raw inputs
//  cmd_valid   in   1      one-cycle strobe: cmd_data holds a command
//  cmd_data    in   32     [31:30] opcode, [N_CH-1:0] channel mask
//  status      out  32     {0, fall_sticky, rise_sticky, level}
//  level       out  N_CH   debounced, polarity-corrected level
//  rise_pulse  out  N_CH   one-cycle pulse when level goes 0->1
//  fall_pulse  out  N_CH   one-cycle pulse when level goes 1->0
//  irq         out  1      event interrupt (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n low, async): sync FFs, counters, level, pulses, sticky flags and irq-enable all 0;
//    status = 0, irq = 0.
//  - Per channel: p = raw_in[i] ^ INVERT_MASK[i] -> 2-FF synchroniser -> s.
//  - Counter: if s == level[i], cnt = 0.
//    If s != level[i] and cnt == DEBOUNCE_CYCLES-1: level[i] <= s, cnt = 0, fire the rise or fall pulse.
//    Otherwise cnt increments.
//  - Latency: a clean step on raw_in settling before edge 1 updates level after edge DEBOUNCE_CYCLES+2.
//    Any excursion shorter than DEBOUNCE_CYCLES sampled cycles produces no change and no pulse.
//  - Pulses are registered, high for exactly one cycle, concurrent with the level update.
//  - Sticky: rise_sticky[i] is set by rise_pulse[i]; fall_sticky[i] is set by fall_pulse[i].
//    Both hold until cleared.
//  - Commands, acted on only when cmd_valid = 1:
//      op 2'b01: clear rise_sticky and fall_sticky for each channel whose mask bit = 1.
//      op 2'b10: irq-enable write (only when IO_EDGE_IRQ_EN is defined).
//      op 2'b00, 2'b11: no effect.
//    Mask bits at and above N_CH are ignored.
//  - Set and clear on the same channel in the same cycle: set wins, so the sticky flag stays 1.
//  - status layout: [N_CH-1:0] level, [2N_CH-1:N_CH] rise_sticky, [3N_CH-1:2N_CH] fall_sticky;
//    remaining bits are 0. status is registered, with the same timing as level and the sticky flags.
//  - Channels are fully independent. Simultaneous events on several channels are all captured.
//  - Reset mid-debounce discards the partial count; level returns to 0.
//    After reset release, a high (post-inversion) input is reported after the normal latency,
//    together with a rise pulse.
// CONFIGURATION
//  IO_EDGE_IRQ_EN defined:
//    - op 2'b10 loads irq_en[N_CH-1:0] from cmd_data[N_CH-1:0].
//    - irq = |((rise_sticky | fall_sticky) & irq_en), registered, so it lags sticky by 1 cycle.
//  IO_EDGE_IRQ_EN undefined:
//    - no irq_en register; irq tied 0; op 2'b10 is a no-op.
// TESTING
//  (All with N_CH=4, DEBOUNCE_CYCLES=8, INVERT_MASK=4'b0010.)
//  1 Reset: hold rst_n=0 with raw_in=4'b1111 -> status=0, level=0, pulses=0, irq=0.
//  2 Step: raw_in[0] 0->1 before edge 1 -> level[0]=1 after edge 10;
//    rise_pulse[0] high 1 cycle; status=32'h0000_0011.
//  3 Glitch: raw_in[2] high for 5 cycles, then low -> level, pulses and status unchanged.
//  4 Inversion: raw_in[1] 1->0 -> level[1]=1, rise_sticky[1]=1.
//    Then cmd op 01 with mask 4'b0010 -> status[5]=0, level[1] still 1.
//  5 Collision: cmd clear of ch0 in the same cycle as fall_pulse[0] -> fall_sticky[0]=1 (set wins).
//  6 IRQ (macro on): op 10 with mask 4'b0001, then ch0 rises -> irq=1 one cycle after the sticky flag;
//    op 01 clear -> irq=0 next cycle. Macro off: irq stays 0 throughout.

Source files
------------

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: per-channel debouncer with edge pulses, sticky event flags and CPU status word
//   Optional feature macro: IO_EDGE_IRQ_EN (edge interrupt with per-channel enable register)
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   raw_in_i     in   [N_CH-1:0] asynchronous raw inputs
//   cmd_valid_i  in   one-cycle command strobe
//   cmd_data_i   in   [31:30] opcode, [N_CH-1:0] channel mask
//   status_o     out  {0, fall_sticky, rise_sticky, level}
//   level_o      out  debounced, polarity-corrected level
//   rise_pulse_o out  one-cycle pulse on level 0->1
//   fall_pulse_o out  one-cycle pulse on level 1->0
//   irq_o        out  event interrupt (0 unless IO_EDGE_IRQ_EN)
module io_input_conditioner #(
  parameter int          N_CH            = 4,
  parameter int          DEBOUNCE_CYCLES = 1000,
  parameter int          CNT_W           = 16,
  parameter logic [31:0] INVERT_MASK     = 32'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in_i,
  input  logic            cmd_valid_i,
  input  logic [31:0]     cmd_data_i,
  output logic [31:0]     status_o,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_pulse_o,
  output logic [N_CH-1:0] fall_pulse_o,
  output logic            irq_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_CH-1:0]  meta_q, sync_q;
  logic [N_CH-1:0]  level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic [N_CH-1:0]  rs_q, rs_d, fs_q, fs_d, clr;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic             unused_cmd;
  assign unused_cmd = ^cmd_data_i;
  // A clear and an event registered at the same edge: the event wins.
  always_comb begin
    clr = (cmd_valid_i && cmd_data_i[31:30] == 2'b01) ? cmd_data_i[N_CH-1:0] : '0;
    level_d = level_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync_q[i];
          rise_d[i] = sync_q[i];
          fall_d[i] = ~sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rs_d = (rs_q & ~clr) | rise_d;
    fs_d = (fs_q & ~clr) | fall_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      level_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      rs_q <= '0;
      fs_q <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q <= raw_in_i ^ INVERT_MASK[N_CH-1:0];
      sync_q <= meta_q;
      level_q <= level_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      rs_q <= rs_d;
      fs_q <= fs_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign status_o = 32'({fs_q, rs_q, level_q});
  assign level_o = level_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
`ifdef IO_EDGE_IRQ_EN
  logic [N_CH-1:0] irq_en_q;
  logic            irq_q;
  // irq is built from the registered sticky flags, so it trails them by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= '0;
      irq_q <= 1'b0;
    end else begin
      irq_en_q <= (cmd_valid_i && cmd_data_i[31:30] == 2'b10) ? cmd_data_i[N_CH-1:0] : irq_en_q;
      irq_q <= |((rs_q | fs_q) & irq_en_q);
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif
endmodule
